// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding,
// default operand width and the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Purely combinational 1-bit full adder cell, the only arithmetic element
// of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: feeds one operand bit pair per cycle, LSB first, through a
// single full-adder cell. Optional signed-overflow output under SERIAL_ADD_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               fa_s, fa_co;
    logic               last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
                psum_d = WIDTH'({fa_s, psum_q} >> 1);
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = fa_co;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = psum_d;
                    cout_d  = fa_co;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
                    // c_q is the carry into the MSB during the final bit.
                    ovf_d   = c_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=3, with a plain
// arithmetic reference model. Covers SERIAL_ADD_OVF_EN when that macro is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result registers may only change in the cycle done is high (or on reset).
    logic [7:0] last8 = '0;
    logic [2:0] last3 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last8 <= '0;
            last3 <= '0;
        end else begin
            n_tests++;
            if (done8) last8 <= sum8;
            else if (sum8 !== last8) begin
                n_fail++;
                $display("FAIL sum8_stable: got %h required %h", sum8, last8);
            end
            n_tests++;
            if (done3) last3 <= sum3;
            else if (sum3 !== last3) begin
                n_fail++;
                $display("FAIL sum3_stable: got %h required %h", sum3, last3);
            end
        end
    end

    // Reference: signed overflow of a+b+cin for a w-bit two's-complement result.
    function automatic logic ref_ovf(input int w, input int av, input int bv, input int ci);
        int sa, sb, s;
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        s  = sa + sb + ci;
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    // Starts one addition (called #1 after an edge with the DUT idle) and waits
    // for done, bounded. Ends #1 after the edge following done.
    task automatic do_add(input bit w3, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, output int lat, output int busy_cnt,
                          output logic done_after, output logic timeout);
        if (w3) begin
            a3 = av[2:0]; b3 = bv[2:0]; cin3 = ci; start3 = 1'b1;
        end else begin
            a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start8 = 1'b0; start3 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
        lat = 0; busy_cnt = 0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (w3 ? busy3 : busy8) busy_cnt++;
            if (w3 ? done3 : done8) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        done_after = w3 ? done3 : done8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; start3 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy8); end
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done8); end
        n_tests++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h required 00", sum8); end
        n_tests++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b required 0", cout8); end
        n_tests++; if ({busy3, done3, cout3, sum3} !== 6'b0) begin
            n_fail++; $display("FAIL reset_w3: got %b required 000000", {busy3, done3, cout3, sum3});
        end
`ifdef SERIAL_ADD_OVF_EN
        n_tests++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf8); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] av [3] = '{8'h00, 8'hFF, 8'h5A};
        logic [7:0] bv [3] = '{8'h00, 8'h01, 8'h25};
        logic       cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h00, 8'h80};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        int lat, bc;
        logic da, to;
        for (int k = 0; k < 3; k++) begin
            do_add(1'b0, av[k], bv[k], cv[k], lat, bc, da, to);
            n_tests++; if (to !== 1'b0 || lat != 8) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d timeout %b required 8", k, lat, to);
            end
            n_tests++; if (bc != 9) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d required 9", k, bc); end
            n_tests++; if (da !== 1'b0 || busy8 !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_done_pulse: got done %b busy %b required 0 0", k, da, busy8);
            end
            n_tests++; if (sum8 !== es[k]) begin n_fail++; $display("FAIL dir%0d_sum: got %h required %h", k, sum8, es[k]); end
            n_tests++; if (cout8 !== ec[k]) begin n_fail++; $display("FAIL dir%0d_cout: got %b required %b", k, cout8, ec[k]); end
`ifdef SERIAL_ADD_OVF_EN
            n_tests++; if (ovf8 !== (k == 2)) begin n_fail++; $display("FAIL dir%0d_ovf: got %b required %b", k, ovf8, k == 2); end
`endif
        end
    endtask

    task automatic test_ignored_start();
        int lat, bc;
        logic da, to, seen;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 4; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        n_tests++; if (!seen || lat != 8) begin n_fail++; $display("FAIL ign_latency: got %0d seen %b required 8", lat, seen); end
        n_tests++; if (sum8 !== 8'h10 || cout8 !== 1'b0) begin
            n_fail++; $display("FAIL ign_result: got %b_%h required 0_10", cout8, sum8);
        end
        @(posedge clk); #1;
        do_add(1'b0, 8'h33, 8'h44, 1'b0, lat, bc, da, to);
        n_tests++; if (to !== 1'b0 || lat != 8 || sum8 !== 8'h77) begin
            n_fail++; $display("FAIL third_start: got sum %h lat %0d required 77 8", sum8, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int dcount;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_tests++; if (busy8 !== 1'b1 || sum8 !== 8'h77) begin
            n_fail++; $display("FAIL pre_abort: got busy %b sum %h required 1 77", busy8, sum8);
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({busy8, done8, cout8, sum8} !== 11'b0) begin
            n_fail++; $display("FAIL async_reset: got %b required all 0", {busy8, done8, cout8, sum8});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dcount++;
        end
        n_tests++; if (dcount != 0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_fail++; $display("FAIL post_abort: got active %0d sum %h cout %b required 0 00 0", dcount, sum8, cout8);
        end
    endtask

    task automatic test_random(input bit w3, input int n);
        int w, av, bv, ci, exp, lat, bc, got;
        logic da, to;
        w = w3 ? 3 : 8;
        for (int k = 0; k < n; k++) begin
            av = int'($urandom_range((1 << w) - 1, 0));
            bv = int'($urandom_range((1 << w) - 1, 0));
            ci = int'($urandom_range(1, 0));
            exp = av + bv + ci;
            do_add(w3, 8'(av), 8'(bv), 1'(ci), lat, bc, da, to);
            got = w3 ? int'({cout3, sum3}) : int'({cout8, sum8});
            n_tests++; if (got != exp) begin
                n_fail++; $display("FAIL rand_w%0d_result: %0d+%0d+%0d got %0d required %0d", w, av, bv, ci, got, exp);
            end
            n_tests++; if (to !== 1'b0 || lat != w || da !== 1'b0) begin
                n_fail++; $display("FAIL rand_w%0d_timing: got lat %0d done_after %b required %0d 0", w, lat, da, w);
            end
`ifdef SERIAL_ADD_OVF_EN
            n_tests++; if ((w3 ? ovf3 : ovf8) !== ref_ovf(w, av, bv, ci)) begin
                n_fail++; $display("FAIL rand_w%0d_ovf: got %b required %b", w, w3 ? ovf3 : ovf8, ref_ovf(w, av, bv, ci));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid_run();
        test_random(1'b0, 200);
        test_random(1'b1, 200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder controller that drives a single 1-bit full-adder cell LSB-first and carries the ripple carry across clock cycles in a flip-flop.
- Sits directly around the full-adder stage. It feeds the cell one operand bit pair per cycle and consumes the cell's sum/carry into a result shift register.
- Trades latency (WIDTH cycles) for area: one full adder regardless of operand width.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse when result becomes valid
- sum  output  WIDTH  result register; holds last completed sum
- cout  output  1  final carry-out of last completed addition

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0. Operand shift registers, carry flop and bit counter are cleared to 0.
- Reset asserted mid-RUN aborts the addition. The partial result is discarded; sum/cout read 0 after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge loads a_sr<=a, b_sr<=b, c<=cin, cnt<=0, psum<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN (one bit per cycle):
  - The full-adder cell sees a_sr[0], b_sr[0], c.
  - psum <= {s, psum[WIDTH-1:1]} (sum bit enters at MSB and shifts right).
  - a_sr and b_sr shift right with zero fill; c <= carry output of the cell; cnt <= cnt+1.
  - When cnt==WIDTH-1, the final shift happens, and in the same edge sum <= {s, psum[WIDTH-1:1]} and cout <= carry. State moves to DONE.
- DONE: done=1 for exactly this cycle, busy=1. Unconditionally return to IDLE on the next edge.
- Latency: start accepted at edge N gives done high during the cycle after edge N+WIDTH. Result is valid from that edge onward.
- Throughput: one addition per WIDTH+2 cycles; a new start is accepted in the cycle after DONE.
- start while busy=1 is ignored, with no queuing. Operand inputs are don't-care except at the accepting edge.
- sum/cout change only at completion (or reset). They never show partial results and are held indefinitely in IDLE.
- cnt width is clog2(WIDTH). No wrap is possible because the FSM leaves RUN at WIDTH-1.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit), which flags two's-complement signed overflow.
  - ovf = (carry into MSB) XOR cout, captured at the completion edge alongside sum.
  - Reset value 0; held like sum.
- Undefined: no ovf port and no extra flop. All other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default WIDTH constant
  - clog2 helper for cnt width
- One natural sub-module: fa_cell, a purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once.
- The carry flop, shift registers and FSM stay in serial_adder.

Test Plan:
- WIDTH=8, a=0x00 b=0x00 cin=0, start pulse -> done at start+9 edges, sum=0x00, cout=0, busy high for 9 cycles.
- a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1 (full carry ripple across all 8 cycles); with SERIAL_ADD_OVF_EN, ovf=0.
- a=0x5A b=0x25 cin=1 -> sum=0x80, cout=0; with SERIAL_ADD_OVF_EN, ovf=1 (90+37+1 overflows signed 8-bit).
- Start a=0x0F b=0x01 cin=0, then pulse start again with a=0xAA at cycle 3 of RUN -> second start ignored, result sum=0x10; a third start right after DONE is accepted.
- Start a=0xFF b=0xFF cin=1, drop rst_n at cycle 4 of RUN -> busy, done, sum and cout go 0 immediately (asynchronously); after release, FSM in IDLE and no done pulse.
- Randomized 200 additions, WIDTH=8 and WIDTH=3, checked against {cout,sum}=a+b+cin with a scoreboard. Also assert done is exactly one cycle and sum is stable between completions.
